regfile_wb_scoreboard: RTL and testbench
========================================

// Module: regfile_wb_scoreboard
// PURPOSE
//  - Shares the single register-file write port between two writeback sources (src0 = EXU, src1 = LSU).
//  - Keeps a per-register busy scoreboard for the issue and decode stages, so no instruction reads or
//    overwrites a register that still has a write pending.
//  - Sits between the IDU/EXU/LSU and the register file; it drives the register file's wen/waddr/wdata.
// PARAMETERS
//  - NR_REG  16  number of architectural registers; x0 is hardwired zero and never tracked
// PORTS
//  - clk          in   1   clock; all state updates on posedge
//  - rstn         in   1   synchronous active-low reset
//  - issue_valid  in   1   an instruction with a register destination wants to issue
//  - issue_rd     in   5   destination register of the issuing instruction
//  - issue_ready  out  1   issue accepted this cycle
//  - src0_valid   in   1   EXU writeback request
//  - src0_rd      in   5   EXU writeback destination
//  - src0_data    in   32  EXU writeback data
//  - src0_ready   out  1   EXU writeback granted
//  - src1_valid   in   1   LSU writeback request
//  - src1_rd      in   5   LSU writeback destination
//  - src1_data    in   32  LSU writeback data
//  - src1_ready   out  1   LSU writeback granted
//  - rf_wen       out  1   register-file write enable
//  - rf_waddr     out  5   register-file write address
//  - rf_wdata     out  32  register-file write data
//  - chk_raddr1   in   5   decode-stage source register 1
//  - chk_raddr2   in   5   decode-stage source register 2
//  - chk_busy     out  1   1 = either source register is pending; decode must stall
// BEHAVIOUR
//  - State:
//    - busy[NR_REG-1:1]
//    - last_grant: 1 bit, the source granted most recently
//  - Reset (rstn=0 at posedge): busy <= 0, last_grant <= 1, so src0 wins the first conflict.
//  - While rstn=0, issue_ready, src0_ready, src1_ready and rf_wen are all forced to 0.
//  - Register index: rd=0 and rd>=NR_REG are treated as x0. Such a register is never busy and is never written.
//  - Issue:
//    - issue_ready = !busy[issue_rd]; this is a combinational output.
//    - Handshake = issue_valid && issue_ready. On a handshake to a tracked rd, busy[rd] is set at the next posedge.
//    - A busy rd blocks issue (WAW stall).
//  - Arbitration (combinational, zero latency):
//    - One valid source: that source gets ready=1.
//    - Both valid: the source that is not last_grant wins (round-robin).
//    - last_grant updates only on a cycle in which a grant occurs.
//    - A source must hold its valid, rd and data stable until it is granted.
//  - Write port:
//    - On a grant, rf_waddr and rf_wdata are taken from the winning source.
//    - rf_wen = grant && rd is tracked.
//    - With no grant, rf_wen=0, rf_waddr=0, rf_wdata=0.
//  - Clear: a granted writeback to a tracked rd clears busy[rd] at the next posedge.
//  - A writeback to a register that is not busy is still written and leaves busy unchanged.
//  - Same-cycle events:
//    - Issue to A plus writeback to B (A != B): busy[A] is set and busy[B] is cleared.
//    - Issue to A plus writeback to A cannot happen (busy[A]=1 forces issue_ready=0). The write occurs,
//      and the issue succeeds on the next cycle.
//  - chk_busy = busy[chk_raddr1] | busy[chk_raddr2], evaluated combinationally from current state; x0 sources return 0.
//  - Reset in mid-operation discards all pending busy bits. Requesters are reset in the same cycle.
// CONFIGURATION
//  - Macro SB_FWD_EN adds the output ports fwd_hit1, fwd_hit2 (1 bit each) and fwd_data (32 bit).
//  - With SB_FWD_EN defined:
//    - fwd_hit = rf_wen && rf_waddr == chk_raddrN.
//    - A hit masks that source's busy bit out of chk_busy.
//    - fwd_data = rf_wdata, so decode consumes the value in the writeback cycle.
//  - Without SB_FWD_EN: the fwd ports do not exist. chk_busy stays 1 until the cycle after the writeback.
// TESTING
//  - Reset, then issue x5 -> busy[5]=1 next cycle. chk_raddr1=5 gives chk_busy=1. A second issue to x5 gets issue_ready=0.
//  - src0 writeback of x5 = 0xDEADBEEF -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in the same cycle; busy[5]=0 next cycle.
//  - Both sources valid for 3 cycles (src0 x3, src1 x4; each reasserts after grant) ->
//    grants go src0, src1, src0; the loser's ready stays 0 while it holds.
//  - Writeback to rd=0 with data 0x1234 -> src0_ready=1, rf_wen=0, scoreboard unchanged.
//  - Issue x7 and writeback x6 in the same cycle with x6 busy -> busy[7]=1, busy[6]=0 after the edge.
//  - With SB_FWD_EN: writeback x9 while chk_raddr2=9 -> fwd_hit2=1, fwd_data=wdata, chk_busy=0.
//    Without SB_FWD_EN: chk_busy=1 in that cycle.

Source files
------------

// File: rtl/regfile_wb_scoreboard_if.sv
// Writeback/issue/decode-check bundle for regfile_wb_scoreboard.
// SB_FWD_EN adds the writeback forwarding outputs.
interface regfile_wb_scoreboard_if;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        src0_valid;
  logic [4:0]  src0_rd;
  logic [31:0] src0_data;
  logic        src0_ready;
  logic        src1_valid;
  logic [4:0]  src1_rd;
  logic [31:0] src1_data;
  logic        src1_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  chk_raddr1;
  logic [4:0]  chk_raddr2;
  logic        chk_busy;
`ifdef SB_FWD_EN
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data;
`endif

  modport master (
    output issue_valid, issue_rd,
    output src0_valid, src0_rd, src0_data,
    output src1_valid, src1_rd, src1_data,
    output chk_raddr1, chk_raddr2,
    input  issue_ready, src0_ready, src1_ready,
    input  rf_wen, rf_waddr, rf_wdata,
`ifdef SB_FWD_EN
    input  fwd_hit1, fwd_hit2, fwd_data,
`endif
    input  chk_busy
  );

  modport slave (
    input  issue_valid, issue_rd,
    input  src0_valid, src0_rd, src0_data,
    input  src1_valid, src1_rd, src1_data,
    input  chk_raddr1, chk_raddr2,
    output issue_ready, src0_ready, src1_ready,
    output rf_wen, rf_waddr, rf_wdata,
`ifdef SB_FWD_EN
    output fwd_hit1, fwd_hit2, fwd_data,
`endif
    output chk_busy
  );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Round-robin writeback arbiter plus per-register busy scoreboard.
// Optional macro SB_FWD_EN: forward the writeback value to decode.
module regfile_wb_scoreboard #(
  parameter int NR_REG = 16
) (
  input logic                  clk,
  input logic                  rstn,
  regfile_wb_scoreboard_if.slave bus
);
  localparam int IW = $clog2(NR_REG);

  logic [NR_REG-1:1] r_busy;
  logic              r_last;
  logic [NR_REG-1:0] w_bvec;
  logic              w_g0;
  logic              w_g1;
  logic              w_grant;
  logic [4:0]        w_wrd;
  logic [31:0]       w_wdat;
  logic              w_wen;
  logic              w_hs;
  logic [NR_REG-1:0] w_set;
  logic [NR_REG-1:0] w_clr;
  logic              w_b1;
  logic              w_b2;

  function automatic logic trk(input logic [4:0] rd);
    return (rd != 5'd0) && (int'(rd) < NR_REG);
  endfunction

  function automatic logic busy_of(
    input logic [4:0]        rd,
    input logic [NR_REG-1:0] v
  );
    return trk(rd) && v[rd[IW-1:0]];
  endfunction

  assign w_bvec = {r_busy, 1'b0};

  // r_last=1 means src1 won last, so src0 has priority
  assign w_g0 = rstn && bus.src0_valid
              && (!bus.src1_valid || r_last);
  assign w_g1 = rstn && bus.src1_valid
              && (!bus.src0_valid || !r_last);
  assign w_grant = w_g0 | w_g1;

  always_comb begin
    w_wrd  = '0;
    w_wdat = '0;
    unique case (1'b1)
      w_g0: begin
        w_wrd  = bus.src0_rd;
        w_wdat = bus.src0_data;
      end
      w_g1: begin
        w_wrd  = bus.src1_rd;
        w_wdat = bus.src1_data;
      end
      default: ;
    endcase
  end

  assign w_wen = w_grant && trk(w_wrd);

  assign bus.src0_ready = w_g0;
  assign bus.src1_ready = w_g1;
  assign bus.rf_wen     = w_wen;
  assign bus.rf_waddr   = w_wrd;
  assign bus.rf_wdata   = w_wdat;

  assign bus.issue_ready = rstn
                         && !busy_of(bus.issue_rd, w_bvec);
  assign w_hs = bus.issue_valid && bus.issue_ready;

  assign w_set = (w_hs && trk(bus.issue_rd))
               ? (NR_REG'(1) << bus.issue_rd[IW-1:0])
               : '0;
  assign w_clr = w_wen
               ? (NR_REG'(1) << w_wrd[IW-1:0])
               : '0;

  assign w_b1 = busy_of(bus.chk_raddr1, w_bvec);
  assign w_b2 = busy_of(bus.chk_raddr2, w_bvec);

`ifdef SB_FWD_EN
  assign bus.fwd_hit1 = w_wen && (w_wrd == bus.chk_raddr1);
  assign bus.fwd_hit2 = w_wen && (w_wrd == bus.chk_raddr2);
  assign bus.fwd_data = w_wdat;
  assign bus.chk_busy = (w_b1 && !bus.fwd_hit1)
                      | (w_b2 && !bus.fwd_hit2);
`else
  assign bus.chk_busy = w_b1 | w_b2;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy <= '0;
      r_last <= 1'b1;
    end else begin
      r_busy <= (r_busy & ~w_clr[NR_REG-1:1])
              | w_set[NR_REG-1:1];
      if (w_grant)
        r_last <= w_g1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed vector bench for regfile_wb_scoreboard.
// Vectors run back to back; each row depends on the state left by the previous.
module tb_regfile_wb_scoreboard;
  logic clk;
  logic rstn;

  regfile_wb_scoreboard_if bus ();

  regfile_wb_scoreboard #(.NR_REG(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        s0v;
    logic [4:0]  s0rd;
    logic [31:0] s0d;
    logic        s1v;
    logic [4:0]  s1rd;
    logic [31:0] s1d;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ir;
    logic        e_s0r;
    logic        e_s1r;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_cb;
  } vec_t;

  vec_t tbl[19];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic iv, input logic [4:0] ird,
    input logic s0v, input logic [4:0] s0rd, input logic [31:0] s0d,
    input logic s1v, input logic [4:0] s1rd, input logic [31:0] s1d,
    input logic [4:0] r1, input logic [4:0] r2,
    input logic ir, input logic s0r, input logic s1r,
    input logic wen, input logic [4:0] wa, input logic [31:0] wd,
    input logic cb);
    vec_t v;
    v.iv = iv; v.ird = ird;
    v.s0v = s0v; v.s0rd = s0rd; v.s0d = s0d;
    v.s1v = s1v; v.s1rd = s1rd; v.s1d = s1d;
    v.r1 = r1; v.r2 = r2;
    v.e_ir = ir; v.e_s0r = s0r; v.e_s1r = s1r;
    v.e_wen = wen; v.e_wa = wa; v.e_wd = wd; v.e_cb = cb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_rd    = v.ird;
    bus.src0_valid  = v.s0v;
    bus.src0_rd     = v.s0rd;
    bus.src0_data   = v.s0d;
    bus.src1_valid  = v.s1v;
    bus.src1_rd     = v.s1rd;
    bus.src1_data   = v.s1d;
    bus.chk_raddr1  = v.r1;
    bus.chk_raddr2  = v.r2;
  endtask

  task automatic check(input int i, input vec_t v);
    string p;
    p = $sformatf("v%0d", i);
    chk({p, ".issue_ready"}, 32'(bus.issue_ready), 32'(v.e_ir));
    chk({p, ".src0_ready"}, 32'(bus.src0_ready), 32'(v.e_s0r));
    chk({p, ".src1_ready"}, 32'(bus.src1_ready), 32'(v.e_s1r));
    chk({p, ".rf_wen"}, 32'(bus.rf_wen), 32'(v.e_wen));
    chk({p, ".rf_waddr"}, 32'(bus.rf_waddr), 32'(v.e_wa));
    chk({p, ".rf_wdata"}, bus.rf_wdata, v.e_wd);
    chk({p, ".chk_busy"}, 32'(bus.chk_busy), 32'(v.e_cb));
  endtask

  vec_t z;

  initial begin
    n_cmp = 0;
    n_err = 0;
    z = mk(0,0, 0,0,0, 0,0,0, 0,0, 1,0,0,0,0,0,0);

    //         iv ird  s0v rd data         s1v rd data     r1 r2  ir s0 s1 wen wa wd           cb
    tbl[0]  = mk(0,0,  0,0,0,             0,0,0,          5,0,   1,0,0,0,0,0,              0);
    tbl[1]  = mk(1,5,  0,0,0,             0,0,0,          5,0,   1,0,0,0,0,0,              0);
    tbl[2]  = mk(1,5,  0,0,0,             0,0,0,          5,0,   0,0,0,0,0,0,              1);
    tbl[3]  = mk(0,5,  1,5,32'hDEADBEEF,  0,0,0,          0,0,   0,1,0,1,5,32'hDEADBEEF,   0);
    tbl[4]  = mk(0,5,  0,0,0,             0,0,0,          5,5,   1,0,0,0,0,0,              0);
    tbl[5]  = mk(0,0,  0,0,0,             1,4,32'h44,     0,0,   1,0,1,1,4,32'h44,         0);
    tbl[6]  = mk(0,0,  1,3,32'h33,        1,4,32'h44,     0,0,   1,1,0,1,3,32'h33,         0);
    tbl[7]  = mk(0,0,  1,3,32'h33,        1,4,32'h44,     0,0,   1,0,1,1,4,32'h44,         0);
    tbl[8]  = mk(0,0,  1,3,32'h33,        1,4,32'h44,     0,0,   1,1,0,1,3,32'h33,         0);
    tbl[9]  = mk(0,0,  1,0,32'h1234,      0,0,0,          0,0,   1,1,0,0,0,32'h1234,       0);
    tbl[10] = mk(1,20, 0,0,0,             1,20,32'hABCD,  0,0,   1,0,1,0,20,32'hABCD,      0);
    tbl[11] = mk(1,6,  0,0,0,             0,0,0,          20,0,  1,0,0,0,0,0,              0);
    tbl[12] = mk(1,7,  1,6,32'h66,        0,0,0,          0,0,   1,1,0,1,6,32'h66,         0);
    tbl[13] = mk(0,6,  0,0,0,             0,0,0,          6,7,   1,0,0,0,0,0,              1);
    tbl[14] = mk(0,7,  0,0,0,             0,0,0,          6,0,   0,0,0,0,0,0,              0);
    tbl[15] = mk(1,9,  0,0,0,             0,0,0,          0,0,   1,0,0,0,0,0,              0);
    tbl[16] = mk(0,9,  0,0,0,             0,0,0,          0,9,   0,0,0,0,0,0,              1);
    tbl[17] = mk(0,9,  0,0,0,             1,9,32'h99,     0,9,   0,0,1,1,9,32'h99,         0);
    tbl[18] = mk(0,9,  0,0,0,             0,0,0,          7,9,   1,0,0,0,0,0,              1);
`ifndef SB_FWD_EN
    tbl[17].e_cb = 1'b1;
`endif

    // Reset: requests present but all grants forced low
    rstn = 1'b0;
    drive(mk(1,5, 1,3,32'h1, 1,4,32'h2, 0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    #2;
    chk("rst.issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("rst.src0_ready", 32'(bus.src0_ready), 32'd0);
    chk("rst.src1_ready", 32'(bus.src1_ready), 32'd0);
    chk("rst.rf_wen", 32'(bus.rf_wen), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive(z);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #2;
      check(i, tbl[i]);
`ifdef SB_FWD_EN
      if (i == 17) begin
        chk("fwd.hit2", 32'(bus.fwd_hit2), 32'd1);
        chk("fwd.hit1", 32'(bus.fwd_hit1), 32'd0);
        chk("fwd.data", bus.fwd_data, 32'h99);
      end
`endif
    end

    // Mid-operation reset drops x7 busy bit
    @(negedge clk);
    rstn = 1'b0;
    drive(mk(1,3, 1,7,32'h7, 1,8,32'h8, 7,0, 0,0,0,0,0,0,0));
    #2;
    chk("mid_rst.src0_ready", 32'(bus.src0_ready), 32'd0);
    chk("mid_rst.src1_ready", 32'(bus.src1_ready), 32'd0);
    chk("mid_rst.rf_wen", 32'(bus.rf_wen), 32'd0);
    chk("mid_rst.issue_ready", 32'(bus.issue_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    drive(mk(0,7, 0,0,0, 0,0,0, 7,0, 0,0,0,0,0,0,0));
    #2;
    chk("post_rst.chk_busy", 32'(bus.chk_busy), 32'd0);
    chk("post_rst.issue_ready", 32'(bus.issue_ready), 32'd1);

    // After reset src0 wins the first conflict again
    @(negedge clk);
    drive(mk(0,0, 1,3,32'hA, 1,4,32'hB, 0,0, 0,0,0,0,0,0,0));
    #2;
    chk("post_rst.arb_src0", 32'(bus.src0_ready), 32'd1);
    chk("post_rst.arb_src1", 32'(bus.src1_ready), 32'd0);
    chk("post_rst.arb_wdata", bus.rf_wdata, 32'hA);
    @(negedge clk);
    drive(z);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
